instr_fetch_unit: RTL and testbench

- Fetch stage for the multicycle RV32I core; sits directly upstream of the control unit.
- Owns the PC register and the instruction register (IR).
- Runs a request/ready handshake with instruction memory and holds the IR stable, so the control unit sees a constant instruction code from DECODE through writeback.
- PC load strobe and next-PC value come from the datapath/control unit.

---
 rtl/instr_fetch_unit.sv | 138 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module   : instr_fetch_unit
// Function : RV32I multicycle fetch stage. Owns the PC and IR registers and
//            runs the request/ready handshake with instruction memory.
//            Optional FETCH_TIMEOUT_EN bounds the wait for imem_ready.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_start,
  input  logic        pc_load,
  input  logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] instr_code,
  output logic        instr_valid,
  output logic        fetch_busy,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_fetch_addr;
  logic        r_valid;
  logic        r_fault;

  logic [31:0] w_start_addr;
  logic        w_misaligned;

`ifdef FETCH_TIMEOUT_EN
  localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [c_CNT_W-1:0] r_wait_cnt;
  logic               w_timeout;

  assign w_timeout = (r_wait_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  // A start coinciding with a PC load fetches from the new PC.
  assign w_start_addr = pc_load ? pc_next : r_pc;
  assign w_misaligned = |w_start_addr[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_ir         <= NOP_INSTR;
      r_fetch_addr <= 32'h0000_0000;
      r_valid      <= 1'b0;
      r_fault      <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      r_wait_cnt   <= '0;
`endif
    end else begin
      r_valid <= 1'b0;

      if (pc_load) begin
        r_pc <= pc_next;
      end

      case (r_state)
        S_IDLE: begin
          if (fetch_start) begin
            r_fetch_addr <= w_start_addr;
            if (w_misaligned) begin
              r_fault <= 1'b1;
              r_ir    <= NOP_INSTR;
              r_valid <= 1'b1;
            end else begin
              r_fault <= 1'b0;
              r_state <= S_REQ;
`ifdef FETCH_TIMEOUT_EN
              r_wait_cnt <= '0;
`endif
            end
          end
        end

        S_REQ: begin
          if (imem_ready) begin
            r_ir    <= imem_rdata;
            r_valid <= 1'b1;
            r_state <= S_RESP;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (w_timeout) begin
            r_fault <= 1'b1;
            r_ir    <= NOP_INSTR;
            r_valid <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
          end
`endif
        end

        S_RESP: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Derived from the state register so an async reset drops the request at once.
  assign imem_req    = (r_state == S_REQ);
  assign imem_addr   = imem_req ? r_fetch_addr : 32'h0000_0000;
  assign fetch_busy  = (r_state != S_IDLE);
  assign pc          = r_pc;
  assign instr_code  = r_ir;
  assign instr_valid = r_valid;
  assign fetch_fault = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: vector table plus scoreboard of expected
// fetch addresses and IR captures.
`default_nettype none

module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        fetch_start;
  logic        pc_load;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] pc;
  logic [31:0] instr_code;
  logic        instr_valid;
  logic        fetch_busy;
  logic        fetch_fault;

  instr_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_start (fetch_start),
    .pc_load     (pc_load),
    .pc_next     (pc_next),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ready  (imem_ready),
    .pc          (pc),
    .instr_code  (instr_code),
    .instr_valid (instr_valid),
    .fetch_busy  (fetch_busy),
    .fetch_fault (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        load;
    logic [31:0] pcn;
    logic [31:0] rdata;
    int          waits;
    logic [31:0] exp_addr;
    logic [31:0] exp_instr;
    logic        exp_fault;
    logic [31:0] exp_pc;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  vec_t        vecs[9];

  int total = 0;
  int bad = 0;
  int n_accept = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: memory accepts and IR update pulses are matched against queues.
  always @(negedge clk) begin
    if (reset) begin
      if (imem_req && imem_ready) begin
        n_accept++;
        if (addr_q.size() == 0) check("unexpected_request", imem_addr, 32'hxxxx_xxxx);
        else check("imem_addr", imem_addr, addr_q.pop_front());
      end
      if (!imem_req) check("imem_addr_idle_zero", imem_addr, 32'h0);
      if (instr_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_instr_valid", 32'(instr_valid), 32'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("instr_code", instr_code, e.instr);
          check("fetch_fault_at_valid", 32'(fetch_fault), 32'(e.fault));
        end
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int acc0;
    acc0 = n_accept;
    fetch_start = 1'b1;
    pc_load     = v.load;
    pc_next     = v.pcn;
    exp_q.push_back('{v.exp_instr, v.exp_fault});
    if (!v.exp_fault) addr_q.push_back(v.exp_addr);
    tick();
    fetch_start = 1'b0;
    pc_load     = 1'b0;
    if (!v.exp_fault) begin
      imem_rdata = v.rdata;
      for (int w = 0; w <= v.waits; w++) begin
        imem_ready = (w == v.waits);
        check("req_phase", 32'(fetch_busy & imem_req), 32'h1);
        tick();
      end
      imem_ready = 1'b0;
      check("resp_busy", 32'(fetch_busy), 32'h1);
      tick();
    end else begin
      check("fault_no_req", 32'(imem_req | fetch_busy), 32'h0);
      tick();
    end
    check("idle_busy", 32'(fetch_busy), 32'h0);
    check("idle_valid", 32'(instr_valid), 32'h0);
    check("pc", pc, v.exp_pc);
    check("ir_hold", instr_code, v.exp_instr);
    check("fault_sticky", 32'(fetch_fault), 32'(v.exp_fault));
    check("accept_count", 32'(n_accept - acc0), v.exp_fault ? 32'h0 : 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    vec_t v;

    //           load  pc_next        rdata          w  exp_addr       exp_instr      flt   exp_pc
    vecs[0] = '{1'b0, 32'h0000_0000, 32'h0050_0093, 0, 32'h0000_0000, 32'h0050_0093, 1'b0, 32'h0000_0000};
    vecs[1] = '{1'b1, 32'h0000_0040, 32'h00B5_0633, 3, 32'h0000_0040, 32'h00B5_0633, 1'b0, 32'h0000_0040};
    vecs[2] = '{1'b1, 32'h0000_0102, 32'hAAAA_AAAA, 0, 32'h0000_0000, NOP,           1'b1, 32'h0000_0102};
    vecs[3] = '{1'b1, 32'h0000_0200, 32'h1234_5678, 1, 32'h0000_0200, 32'h1234_5678, 1'b0, 32'h0000_0200};
    vecs[4] = '{1'b0, 32'h0000_0000, 32'hDEAD_BEEF, 2, 32'h0000_0200, 32'hDEAD_BEEF, 1'b0, 32'h0000_0200};
    vecs[5] = '{1'b1, 32'hFFFF_FFFC, 32'h0000_006F, 0, 32'hFFFF_FFFC, 32'h0000_006F, 1'b0, 32'hFFFF_FFFC};
    vecs[6] = '{1'b1, 32'h0000_0003, 32'h5555_5555, 0, 32'h0000_0000, NOP,           1'b1, 32'h0000_0003};
    vecs[7] = '{1'b0, 32'h0000_0000, 32'h5555_5555, 0, 32'h0000_0000, NOP,           1'b1, 32'h0000_0003};
    vecs[8] = '{1'b1, 32'h0000_0008, 32'h0020_8133, 0, 32'h0000_0008, 32'h0020_8133, 1'b0, 32'h0000_0008};

    reset       = 1'b0;
    fetch_start = 1'b0;
    pc_load     = 1'b0;
    pc_next     = 32'h0;
    imem_rdata  = 32'h0;
    imem_ready  = 1'b0;
    tick();
    check("rst_pc", pc, 32'h0);
    check("rst_ir", instr_code, NOP);
    check("rst_outs", {28'h0, imem_req, instr_valid, fetch_busy, fetch_fault}, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // PC update and extra starts during an outstanding fetch.
    acc0 = n_accept;
    fetch_start = 1'b1; pc_load = 1'b1; pc_next = 32'h0000_0040;
    exp_q.push_back('{32'h00A0_0513, 1'b0});
    addr_q.push_back(32'h0000_0040);
    tick();
    pc_load = 1'b1; pc_next = 32'h0000_0100; fetch_start = 1'b1; imem_ready = 1'b0;
    check("inflight_addr0", imem_addr, 32'h0000_0040);
    tick();
    pc_load = 1'b0;
    check("inflight_addr1", imem_addr, 32'h0000_0040);
    check("inflight_pc", pc, 32'h0000_0100);
    tick();
    imem_ready = 1'b1; imem_rdata = 32'h00A0_0513;
    check("inflight_addr2", imem_addr, 32'h0000_0040);
    tick();
    imem_ready = 1'b0;
    tick();
    fetch_start = 1'b0;
    check("busy_start_ignored", 32'(fetch_busy | imem_req), 32'h0);
    check("single_request", 32'(n_accept - acc0), 32'h1);
    check("pc_after", pc, 32'h0000_0100);
    check("fault_clear", 32'(fetch_fault), 32'h0);

    v = '{1'b0, 32'h0, 32'h0000_0073, 0, 32'h0000_0100, 32'h0000_0073, 1'b0, 32'h0000_0100};
    run_vec(v);

    // Async reset in the middle of a request.
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    imem_ready = 1'b0;
    check("pre_reset_req", 32'(imem_req), 32'h1);
    tick();
    #2;
    reset = 1'b0;
    exp_q.delete();
    addr_q.delete();
    #1;
    check("reset_req_drop", 32'(imem_req), 32'h0);
    check("reset_addr", imem_addr, 32'h0);
    check("reset_pc", pc, 32'h0);
    check("reset_ir", instr_code, NOP);
    check("reset_busy", 32'(fetch_busy | fetch_fault | instr_valid), 32'h0);
    tick();
    imem_ready = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    tick();
    reset = 1'b1;
    tick();
    tick();
    check("late_data_ignored", instr_code, NOP);
    check("late_data_idle", 32'(instr_valid | fetch_busy), 32'h0);
    imem_ready = 1'b0;

`ifdef FETCH_TIMEOUT_EN
    fetch_start = 1'b1;
    exp_q.push_back('{NOP, 1'b1});
    tick();
    fetch_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("timeout_req_held", 32'(imem_req), 32'h1);
      tick();
    end
    check("timeout_req_drop", 32'(imem_req | fetch_busy), 32'h0);
    check("timeout_fault", 32'(fetch_fault), 32'h1);
    imem_ready = 1'b1; imem_rdata = 32'h1111_1111;
    tick();
    imem_ready = 1'b0;
    check("timeout_late_ready", instr_code, NOP);
    check("timeout_idle", 32'(instr_valid), 32'h0);
`endif

    tick();
    check("scoreboard_empty", 32'(exp_q.size() + addr_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
